alu_seq_gen: RTL and testbench

Sequential operand feeder and result collector around the team's combinational alu block. It loads two seed operands through a valid/ready input, then on each step pulse applies the selected ALU op to the two held operands and shifts the window: a <= b, b <= y. This produces Fibonacci-style recurrences (add, sub, and, or, xor) for the board-level lab top, which drives it from switches/buttons and displays out_data.

---
 rtl/alu_seq_gen_pkg.sv | 19 +
 rtl/alu_seq_gen_alu.sv | 27 ++
 rtl/alu_seq_gen.sv | 108 ++++++++++
 tb/tb_alu_seq_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_gen_pkg.sv
// Shared op codes and sequencer state encoding for the alu and alu_seq_gen blocks.
// Pure declarations; no latency and no flow control.
package alu_seq_gen_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_RUN    = 3'd2,
    ST_ERR    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_gen_alu.sv
// Combinational ALU: y = a <f> b modulo 2^WIDTH, z flags an unsupported function code.
// Zero latency; no backpressure.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             z
);
  import alu_seq_gen_pkg::*;

  always_comb begin
    y = '0;
    z = 1'b0;
    case (f)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: z = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_gen.sv
// Seeds two operands, then each step computes y = alu(a, b) and slides the window a <= b, b <= y.
// One-cycle step-to-out_valid latency; seeds are refused (in_ready=0) outside IDLE/LOAD_B.
module alu_seq_gen #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 8,
  parameter int N_TERMS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             step,
  input  logic             clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic             done
);
  import alu_seq_gen_pkg::*;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_z;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a (a_q),
    .b (b_q),
    .f (op),
    .y (alu_y),
    .z (alu_z)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    count_d     = count_q;
    if (clr) begin
      state_d    = ST_IDLE;
      a_d        = '0;
      b_d        = '0;
      out_data_d = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          a_d     = in_data;
          state_d = ST_LOAD_B;
        end
        ST_LOAD_B: if (in_valid) begin
          b_d        = in_data;
          out_data_d = in_data;
          count_d    = '0;
          state_d    = ST_RUN;
        end
        ST_RUN: if (step) begin
          // Illegal op freezes the datapath and parks the FSM until clr/rst.
          if (alu_z) begin
            state_d = ST_ERR;
          end else begin
            a_d         = b_q;
            b_d         = alu_y;
            out_data_d  = alu_y;
            out_valid_d = 1'b1;
            count_d     = count_q + CNT_W'(1);
            if (count_d == CNT_W'(N_TERMS)) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD_B);
  assign err       = (state_q == ST_ERR);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_alu_seq_gen.sv
// Drives two alu_seq_gen instances (N_TERMS 16 and 4) with shared directed and random stimulus.
// Outputs are compared every cycle against a behavioural reference plus directed constants.
module tb_alu_seq_gen;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;
  localparam int P_IDLE = 0, P_LOADB = 1, P_RUN = 2, P_ERR = 3, P_DONE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [2:0]       op = 3'd0;
  logic             step = 1'b0;
  logic             clr = 1'b0;

  logic             in_ready [2];
  logic             out_valid[2];
  logic [WIDTH-1:0] out_data [2];
  logic [CNT_W-1:0] count    [2];
  logic             err      [2];
  logic             done     [2];

  int n_checks = 0;
  int n_errors = 0;

  int               m_ph [2];
  logic [WIDTH-1:0] m_a  [2];
  logic [WIDTH-1:0] m_b  [2];
  logic [WIDTH-1:0] m_out[2];
  logic             m_vld[2];
  int               m_cnt[2];

  always #5 clk = ~clk;

  alu_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .N_TERMS(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
    .op(op), .step(step), .clr(clr), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .count(count[0]), .err(err[0]), .done(done[0])
  );

  alu_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .N_TERMS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
    .op(op), .step(step), .clr(clr), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .count(count[1]), .err(err[1]), .done(done[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] f, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Applies the inputs present at the clock edge to both reference copies.
  task automatic model_clock();
    logic [WIDTH-1:0] y;
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 1'b0;
      if (rst || clr) begin
        m_ph[k] = P_IDLE; m_a[k] = '0; m_b[k] = '0; m_out[k] = '0; m_cnt[k] = 0;
      end else if (m_ph[k] == P_IDLE && in_valid) begin
        m_a[k] = in_data; m_ph[k] = P_LOADB;
      end else if (m_ph[k] == P_LOADB && in_valid) begin
        m_b[k] = in_data; m_out[k] = in_data; m_cnt[k] = 0; m_ph[k] = P_RUN;
      end else if (m_ph[k] == P_RUN && step) begin
        if (op > 3'd4) begin
          m_ph[k] = P_ERR;
        end else begin
          y = ref_alu(op, m_a[k], m_b[k]);
          m_a[k] = m_b[k]; m_b[k] = y; m_out[k] = y; m_vld[k] = 1'b1;
          m_cnt[k]++;
          if (m_cnt[k] == (k == 0 ? 16 : 4)) m_ph[k] = P_DONE;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_rdy", k), 64'(in_ready[k]),
          64'(m_ph[k] == P_IDLE || m_ph[k] == P_LOADB));
      chk($sformatf("d%0d_vld", k), 64'(out_valid[k]), 64'(m_vld[k]));
      chk($sformatf("d%0d_dat", k), 64'(out_data[k]), 64'(m_out[k]));
      chk($sformatf("d%0d_cnt", k), 64'(count[k]), 64'(m_cnt[k]));
      chk($sformatf("d%0d_err", k), 64'(err[k]), 64'(m_ph[k] == P_ERR));
      chk($sformatf("d%0d_done", k), 64'(done[k]), 64'(m_ph[k] == P_DONE));
    end
  endtask

  task automatic seed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    in_valid = 1'b1; in_data = x; cycle();
    in_data = y; cycle();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic do_step(input logic [2:0] f);
    op = f; step = 1'b1; cycle();
    step = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; cycle();
    clr = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] fib_exp [5];
    fib_exp = '{32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = P_IDLE; m_a[k] = '0; m_b[k] = '0; m_out[k] = '0; m_vld[k] = 1'b0; m_cnt[k] = 0;
    end
    rst = 1'b1; cycle(); cycle();
    chk("rst_rdy", 64'(in_ready[0]), 64'd1);
    chk("rst_dat", 64'(out_data[0]), 64'd0);
    rst = 1'b0;

    // Fibonacci with add
    seed(32'd1, 32'd1);
    chk("seed_novld", 64'(out_valid[0]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      do_step(3'b000);
      chk($sformatf("fib%0d", i), 64'(out_data[0]), 64'(fib_exp[i]));
      chk($sformatf("fib_vld%0d", i), 64'(out_valid[0]), 64'd1);
    end
    chk("fib_cnt", 64'(count[0]), 64'd5);
    chk("fib_done", 64'(done[0]), 64'd0);
    cycle();
    chk("vld_one_cycle", 64'(out_valid[0]), 64'd0);
    do_clr();

    // Subtraction
    seed(32'd5, 32'd3);
    do_step(3'b001); chk("sub0", 64'(out_data[0]), 64'd2);
    do_step(3'b001); chk("sub1", 64'(out_data[0]), 64'd1);
    chk("sub_cnt", 64'(count[0]), 64'd2);
    do_clr();

    // Wrap-around, then illegal op
    seed(32'hFFFF_FFFF, 32'h0000_0001);
    do_step(3'b000); chk("wrap0", 64'(out_data[0]), 64'd0);
    do_step(3'b000); chk("wrap1", 64'(out_data[0]), 64'd1);
    do_step(3'b101);
    chk("illegal_err", 64'(err[0]), 64'd1);
    chk("illegal_vld", 64'(out_valid[0]), 64'd0);
    chk("illegal_dat", 64'(out_data[0]), 64'd1);
    chk("illegal_cnt", 64'(count[0]), 64'd2);
    do_step(3'b000);
    chk("err_sticky", 64'(err[0]), 64'd1);
    chk("err_held_dat", 64'(out_data[0]), 64'd1);
    do_clr();
    chk("clr_err", 64'(err[0]), 64'd0);
    chk("clr_rdy", 64'(in_ready[0]), 64'd1);

    // Termination at N_TERMS on the short instance
    seed(32'd1, 32'd1);
    for (int i = 0; i < 6; i++) begin
      do_step(3'b000);
      if (i >= 4) chk($sformatf("post_done_vld%0d", i), 64'(out_valid[1]), 64'd0);
    end
    chk("n4_done", 64'(done[1]), 64'd1);
    chk("n4_cnt", 64'(count[1]), 64'd4);
    do_clr();

    // clr beats step; rst mid-run
    seed(32'd7, 32'd9);
    do_step(3'b010);
    clr = 1'b1; step = 1'b1; cycle(); clr = 1'b0; step = 1'b0;
    chk("clr_step_vld", 64'(out_valid[0]), 64'd0);
    chk("clr_step_dat", 64'(out_data[0]), 64'd0);
    seed(32'd7, 32'd9);
    do_step(3'b011);
    rst = 1'b1; step = 1'b1; cycle(); rst = 1'b0; step = 1'b0;
    chk("rst_run_dat", 64'(out_data[0]), 64'd0);
    chk("rst_run_rdy", 64'(in_ready[0]), 64'd1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = $urandom;
      op       = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      step     = ($urandom_range(0, 1) == 1);
      clr      = ($urandom_range(0, 40) == 0);
      rst      = ($urandom_range(0, 150) == 0);
      cycle();
    end
    in_valid = 1'b0; step = 1'b0; clr = 1'b0; rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
